uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter: BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after a tx_valid pulse.
REQ-003 Port: clk  input  1  single clock; one clock, all logic on posedge clk.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: req_valid  input  4  per-requester message pending; held high until acked.
REQ-006 Port: req_len  input  4  per-requester length: 0 = 1 byte, 1 = 2 bytes.
REQ-007 Port: req_data  input  64  per-requester payload; requester i uses bits [16i+15:16i]; byte0 = [16i+7:16i], byte1 = [16i+15:16i+8].
REQ-008 Port: req_ack  output  4  one-cycle pulse; message i is latched.
REQ-009 Port: tx_data  output  8  byte to the UART transmitter.
REQ-010 Port: tx_valid  output  1  one-cycle strobe to the UART transmitter.
REQ-011 Port: tx_busy  input  1  UART transmitter busy.
REQ-012 Port: arb_busy  output  1  high in any state other than IDLE.
REQ-013 Port: active_id  output  2  index of the requester being serviced; holds the last value in IDLE.
REQ-014 Port: timeout_pulse  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Function
REQ-015 States: IDLE, SEND, WAIT_BUSY, WAIT_IDLE.
REQ-016 IDLE, any req_valid high:
- select the winner per REQ-022;
- latch its req_len and req_data;
- pulse its req_ack on the next cycle;
- set active_id and byte_idx = 0;
- go to SEND.
REQ-017 SEND, tx_busy low: drive tx_data = latched byte[byte_idx] with tx_valid = 1 for exactly one cycle, clear the timeout counter, go to WAIT_BUSY. With tx_busy high, remain in SEND.
REQ-018 WAIT_BUSY:
- tx_busy high: go to WAIT_IDLE;
- otherwise increment the timeout counter;
- counter reaching BUSY_TIMEOUT: pulse timeout_pulse and go to WAIT_IDLE.
REQ-019 WAIT_IDLE, tx_busy low:
- byte_idx < latched length: increment byte_idx, go to SEND;
- otherwise go to IDLE.
REQ-020 A 2-byte message is atomic: no other requester's byte is interleaved between byte0 and byte1.
REQ-021 Requests that arrive while arb_busy = 1 are not acked. They are evaluated on the first IDLE cycle.
REQ-022 Default arbitration is round-robin:
- search starts at (last_grant + 1) mod 4 and wraps 3 -> 0;
- last_grant updates at each grant.
REQ-023 Requester i deasserting req_valid before ack withdraws its request with no side effect. Deasserting after ack has no effect on the message in flight.
REQ-024 Minimum IDLE-to-IDLE for a 1-byte message with an idle UART is 4 cycles plus the UART busy time.
REQ-025 tx_valid is never asserted while tx_busy = 1.

Reset
REQ-026 rst = 1 forces:
- state IDLE;
- tx_valid, tx_data, req_ack, timeout_pulse, arb_busy = 0;
- active_id = 0;
- last_grant = 3, so requester 0 wins first;
- byte_idx and timeout counter = 0.
REQ-027 Reset mid-message abandons the message without issuing further bytes and without re-acking; requesters must re-present.

Configuration
REQ-028 Macro TX_ARB_FIXED_PRIO_EN:
- defined: fixed priority, requester 0 highest and 3 lowest, and last_grant is unused;
- undefined: round-robin per REQ-022.

Verification
REQ-029 Single 1-byte request: req_valid = 0001, req_len = 0, byte0 = 0x55, UART idle -> req_ack = 0001 once, then one tx_valid with tx_data = 0x55, then arb_busy returns to 0.
REQ-030 2-byte atomicity: requester 2 sends {0xA1, 0x7C} with len = 1, while requester 0 raises a 1-byte 0x55 after the 0xA1 strobe -> UART sequence is 0xA1, 0x7C, 0x55.
REQ-031 Round-robin (macro undefined): all four valid and held, 1-byte payloads 0x10..0x13 -> grant order 0, 1, 2, 3, with 0 granted only once per round. Macro defined, all held with a re-presenting requester 0 -> requester 0 granted every time.
REQ-032 Busy timeout: tx_busy held 0 after the strobe -> timeout_pulse exactly 16 cycles after tx_valid, and the message completes.
REQ-033 Reset mid-message: rst asserted during WAIT_IDLE of a 2-byte message -> byte1 is never sent, all outputs 0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: arbitrates four 1-2 byte message requesters onto a single UART transmitter.
// Define TX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest); round-robin otherwise.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_len,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_busy,
    output logic                   arb_busy,
    output logic [1:0]             active_id,
    output logic                   timeout_pulse
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_IDLE = 2'd3;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    logic [1:0]    state;
    logic          len_q;
    logic [15:0]   data_q;
    logic          byte_idx;
    logic [TW-1:0] tcnt;
    logic [1:0]    win;

`ifdef TX_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[k]) win = 2'(k);
    end
`else
    logic [1:0] last_grant;
    // Later iterations override earlier ones, so offset 1 from last_grant ends up highest priority.
    always_comb begin
        win = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_valid[last_grant + 2'(k)]) win = last_grant + 2'(k);
    end
`endif

    assign arb_busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            req_ack       <= '0;
            timeout_pulse <= 1'b0;
            active_id     <= '0;
            byte_idx      <= 1'b0;
            tcnt          <= '0;
            len_q         <= 1'b0;
            data_q        <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
            last_grant    <= 2'd3;
`endif
        end else begin
            tx_valid      <= 1'b0;
            req_ack       <= '0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    req_ack    <= NUM_REQ'(1) << win;
                    len_q      <= req_len[win];
                    data_q     <= req_data[16*win +: 16];
                    active_id  <= win;
                    byte_idx   <= 1'b0;
`ifndef TX_ARB_FIXED_PRIO_EN
                    last_grant <= win;
`endif
                    state      <= SEND;
                end
                SEND: if (!tx_busy) begin
                    tx_valid <= 1'b1;
                    tx_data  <= byte_idx ? data_q[15:8] : data_q[7:0];
                    tcnt     <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    state <= WAIT_IDLE;
                end else begin
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                        timeout_pulse <= 1'b1;
                        state         <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: if (!tx_busy) begin
                    byte_idx <= byte_idx < len_q ? 1'b1 : byte_idx;
                    state    <= byte_idx < len_q ? SEND : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a small UART busy model and auto-dropping requesters.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_len = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic        arb_busy;
    logic [1:0]  active_id;
    logic        timeout_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_len = 3;
    int busy_cnt = 0;
    bit start_busy = 0;
    logic [3:0] hold_mask = '0;
    int grants[$];
    logic [7:0] bytes[$];
    int ack_cnt, to_cnt, tv_cyc, to_cyc;
    logic [3:0] first_ack;

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len), .req_data(req_data),
        .req_ack(req_ack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .arb_busy(arb_busy), .active_id(active_id), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic clear_logs();
        grants.delete();
        bytes.delete();
        ack_cnt = 0; to_cnt = 0; tv_cyc = -1; to_cyc = -1; first_ack = '0;
    endtask

    // One clock: sample outputs 1ns after the edge, then update requesters and the UART model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (req_ack != 0) begin
            if (ack_cnt == 0) first_ack = req_ack;
            ack_cnt++;
            for (int i = 0; i < 4; i++)
                if (req_ack[i]) begin
                    grants.push_back(i);
                    if (!hold_mask[i]) req_valid[i] = 1'b0;
                end
        end
        if (timeout_pulse) begin to_cnt++; to_cyc = cyc; end
        if (busy_cnt > 0) busy_cnt--;
        if (start_busy) begin busy_cnt = busy_len; start_busy = 0; end
        if (tx_valid) begin
            bytes.push_back(tx_data);
            tv_cyc = cyc;
            n_cmp++;
            if (tx_busy !== 1'b0) begin n_err++; $display("FAIL valid_while_busy: tx_busy=%b required 0", tx_busy); end
            if (busy_len > 0) start_busy = 1;
        end
        tx_busy = busy_cnt > 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int max);
        int n = 0;
        do begin step(); n++; end while ((arb_busy || req_valid != 0) && n < max);
        n_cmp++;
        if (arb_busy || req_valid != 0) begin
            n_err++;
            $display("FAIL %s_timeout: arb_busy=%b req_valid=%b after %0d cycles, required idle", name, arb_busy, req_valid, n);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp += 6;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL %s_tx_valid: got %b required 0", name, tx_valid); end
        if (tx_data !== 8'h00) begin n_err++; $display("FAIL %s_tx_data: got %h required 00", name, tx_data); end
        if (req_ack !== 4'h0) begin n_err++; $display("FAIL %s_req_ack: got %b required 0000", name, req_ack); end
        if (timeout_pulse !== 1'b0) begin n_err++; $display("FAIL %s_timeout_pulse: got %b required 0", name, timeout_pulse); end
        if (arb_busy !== 1'b0) begin n_err++; $display("FAIL %s_arb_busy: got %b required 0", name, arb_busy); end
        if (active_id !== 2'd0) begin n_err++; $display("FAIL %s_active_id: got %0d required 0", name, active_id); end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp[$]);
        n_cmp++;
        if (bytes.size() != exp.size()) begin n_err++; $display("FAIL %s_byte_count: got %0d required %0d", name, bytes.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [7:0] got;
            got = i < bytes.size() ? bytes[i] : 8'hxx;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL %s_byte%0d: got %h required %h", name, i, got, exp[i]); end
        end
    endtask

    task automatic test_reset();
        clear_logs();
        do_reset();
        step();
        check_zero_outputs("reset");
    endtask

    task automatic test_single();
        clear_logs();
        busy_len = 3;
        req_len = '0;
        req_data[15:0] = 16'h0055;
        req_valid = 4'b0001;
        run_until_idle("single", 40);
        n_cmp += 3;
        if (ack_cnt != 1) begin n_err++; $display("FAIL single_ack_count: got %0d required 1", ack_cnt); end
        if (first_ack !== 4'b0001) begin n_err++; $display("FAIL single_ack_value: got %b required 0001", first_ack); end
        if (to_cnt != 0) begin n_err++; $display("FAIL single_timeouts: got %0d required 0", to_cnt); end
        check_bytes("single", '{8'h55});
    endtask

    task automatic test_atomic();
        int n = 0;
        clear_logs();
        busy_len = 3;
        req_len[2] = 1'b1;
        req_data[47:32] = 16'h7CA1;
        req_valid[2] = 1'b1;
        while (bytes.size() == 0 && n < 20) begin step(); n++; end
        req_len[0] = 1'b0;
        req_data[15:0] = 16'h0055;
        req_valid[0] = 1'b1;
        run_until_idle("atomic", 80);
        check_bytes("atomic", '{8'hA1, 8'h7C, 8'h55});
        n_cmp += 2;
        if (grants.size() != 2 || grants[0] != 2 || grants[1] != 0) begin n_err++; $display("FAIL atomic_grants: got %p required 2,0", grants); end
        if (active_id !== 2'd0) begin n_err++; $display("FAIL atomic_active_id: got %0d required 0", active_id); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int exp_g[5];
        logic [7:0] exp_b[$];
        do_reset();
        clear_logs();
        busy_len = 2;
        hold_mask = 4'b0001;
        req_len = '0;
        req_data = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        req_valid = 4'b1111;
        while (grants.size() < 5 && n < 300) begin step(); n++; end
        hold_mask = '0;
        req_valid[0] = 1'b0;
        run_until_idle("rr", 200);
`ifdef TX_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
        exp_b = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
        exp_g = '{0, 1, 2, 3, 0};
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
        for (int i = 0; i < 5; i++) begin
            int g;
            logic [7:0] b;
            g = i < grants.size() ? grants[i] : -1;
            b = i < bytes.size() ? bytes[i] : 8'hxx;
            n_cmp += 2;
            if (g != exp_g[i]) begin n_err++; $display("FAIL rr_grant%0d: got %0d required %0d", i, g, exp_g[i]); end
            if (b !== exp_b[i]) begin n_err++; $display("FAIL rr_byte%0d: got %h required %h", i, b, exp_b[i]); end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        busy_len = 0;
        req_len[1] = 1'b0;
        req_data[31:16] = 16'h003C;
        req_valid = 4'b0010;
        run_until_idle("timeout", 60);
        n_cmp += 2;
        if (to_cnt != 1) begin n_err++; $display("FAIL timeout_count: got %0d required 1", to_cnt); end
        if (to_cyc - tv_cyc != 16) begin n_err++; $display("FAIL timeout_delay: got %0d required 16", to_cyc - tv_cyc); end
        check_bytes("timeout", '{8'h3C});
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_logs();
        busy_len = 5;
        req_len[3] = 1'b1;
        req_data[63:48] = 16'h8899;
        req_valid = 4'b1000;
        while (!(bytes.size() == 1 && tx_busy) && n < 30) begin step(); n++; end
        step();
        do_reset();
        check_zero_outputs("reset_mid");
        repeat (20) step();
        check_bytes("reset_mid", '{8'h99});
        clear_logs();
        busy_len = 2;
        req_len[0] = 1'b0;
        req_len[2] = 1'b0;
        req_data[15:0] = 16'h00AA;
        req_data[47:32] = 16'h00BB;
        req_valid = 4'b0101;
        run_until_idle("after_reset", 80);
        n_cmp += 2;
        if (grants.size() < 1 || grants[0] != 0) begin n_err++; $display("FAIL after_reset_first_grant: got %p required 0 first", grants); end
        if (active_id !== 2'd2) begin n_err++; $display("FAIL after_reset_active_id: got %0d required 2", active_id); end
        check_bytes("after_reset", '{8'hAA, 8'hBB});
    endtask

    initial begin
        test_reset();
        test_single();
        test_atomic();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
